result_unloader: RTL

Reads a square result matrix out of data memory through the memory's single read/write port and streams it to the UART transmitter as a byte stream. It is the outbound counterpart of the inbound load path, which writes words into data memory through the receive port. Each 12-bit word is sent as two bytes, high byte first. It sits between datamemory's addr/dataout port (through the core/unloader address mux) and uart_tx.

---
 rtl/unload_pkg.sv | 22 ++
 rtl/result_unloader.sv | 119 +++++++++++
 2 files changed

// File: rtl/unload_pkg.sv
// Purpose: shared types and widths for the result unloader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package unload_pkg;

  localparam int ADDR_W = 12;
  localparam int WORD_W = 12;
  localparam int BYTE_W = 8;

  // Upper nibble of the high byte; a 12-bit word only fills 4 bits of it.
  localparam logic [3:0] HI_PAD = 4'b0;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_CAP,
    SEND_HI,
    SEND_LO,
    DONE
  } state_t;

endpackage

// File: rtl/result_unloader.sv
// Purpose: stream a MAT_DIM x MAT_DIM matrix from data memory to the UART as hi/lo byte pairs.
// Latency: first tx_valid two edges after start; 4 cycles per word with tx_ready held high.
// Backpressure: tx_valid/tx_data hold until tx_ready; the memory walk stalls with the byte stream.
module result_unloader
  import unload_pkg::*;
#(
  parameter int BASE_ADDR  = 4,
  parameter int ROW_STRIDE = 64,
  parameter int MAT_DIM    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [WORD_W-1:0] mem_data,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(ROW_STRIDE);
  localparam logic [6:0]        LAST   = 7'(MAT_DIM - 1);

  state_t              state;
  state_t              state_nxt;
  logic [6:0]          row;
  logic [6:0]          col;
  logic [ADDR_W-1:0]   row_base;
  logic [BYTE_W-1:0]   word_lo;
  logic                hs;
  logic                last_elem;

  assign hs        = tx_valid && tx_ready;
  assign last_elem = (row == LAST) && (col == LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode: the send states advance only on a byte handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = RD_CAP;
      RD_CAP:  state_nxt = SEND_HI;
      SEND_HI: if (hs) state_nxt = SEND_LO;
      SEND_LO: if (hs) state_nxt = last_elem ? DONE : RD_WAIT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: address walk (row base + column, no multiplier), byte staging, status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_addr  <= BASE;
      row_base  <= BASE;
      row       <= '0;
      col       <= '0;
      mem_rd_en <= 1'b0;
      word_lo   <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mem_addr  <= BASE;
            row_base  <= BASE;
            row       <= '0;
            col       <= '0;
            busy      <= 1'b1;
            mem_rd_en <= 1'b1;
          end
        end
        RD_CAP: begin
          word_lo  <= mem_data[7:0];
          tx_data  <= {HI_PAD, mem_data[11:8]};
          tx_valid <= 1'b1;
        end
        SEND_HI: begin
          if (hs) tx_data <= word_lo;
        end
        SEND_LO: begin
          if (hs) begin
            tx_valid <= 1'b0;
            if (last_elem) begin
              mem_rd_en <= 1'b0;
              done      <= 1'b1;
            end else if (col == LAST) begin
              col      <= '0;
              row      <= row + 7'd1;
              row_base <= row_base + STRIDE;
              mem_addr <= row_base + STRIDE;
            end else begin
              col      <= col + 7'd1;
              mem_addr <= mem_addr + 12'd1;
            end
          end
        end
        DONE: begin
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
